// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register, placed directly after the register file.
//
// Captures the decoded operands, the immediate and the control bundle into EX.
// It also does three things on the way in:
//   - Operand bypass: a write that WB makes this cycle replaces stale register-file read data.
//   - Load-use hazards: if the instruction in ID needs the result of a load that is still in
//     EX, it stalls ID for one cycle and sends a bubble into EX.
//   - Branch flush: kills the instruction that would otherwise enter EX.
// A saturating counter of inserted load-use bubbles is kept for debug.
//
// Ports:
//   clk_i, rst_i             clock; asynchronous active-high reset
//   id_*_i                   ID-stage instruction: valid, RS/RT/RD addresses, RS/RT data,
//                            immediate, control bundle (bit0 RegWrite, bit1 MemRead, bit2 MemWrite)
//   wb_regwrite_i/addr/data  register-file write happening this cycle (bypass source)
//   flush_i                  branch taken: the instruction entering EX becomes a bubble
//   stall_o                  hold PC and IF/ID this cycle (combinational)
//   ex_*_o                   registered EX-stage copy of the ID fields
//   bubble_cnt_o             number of load-use bubbles inserted; saturates at all-ones
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_addr_i,
  input  logic [ADDR_W-1:0] id_rt_addr_i,
  input  logic [ADDR_W-1:0] id_rd_addr_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              wb_regwrite_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [ADDR_W-1:0] ex_rs_addr_o,
  output logic [ADDR_W-1:0] ex_rt_addr_o,
  output logic [ADDR_W-1:0] ex_rd_addr_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam int unsigned MemReadBit = 1;

  logic              valid_q,   valid_d;
  logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic [ADDR_W-1:0] rt_addr_q, rt_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  logic              wb_live;
  logic [DATA_W-1:0] rs_byp, rt_byp;
  logic              hz;

  // Register 0 is hard-wired zero, so a write to it must never be forwarded.
  assign wb_live = wb_regwrite_i && (wb_addr_i != '0);
  assign rs_byp  = (wb_live && (wb_addr_i == id_rs_addr_i)) ? wb_data_i : id_rs_data_i;
  assign rt_byp  = (wb_live && (wb_addr_i == id_rt_addr_i)) ? wb_data_i : id_rt_data_i;

  // The load in EX has no data until MEM, so a dependent instruction in ID must wait one slot.
  assign hz = valid_q && ctrl_q[MemReadBit] && (rd_addr_q != '0) && id_valid_i &&
              ((rd_addr_q == id_rs_addr_i) || (rd_addr_q == id_rt_addr_i));

  // A taken branch discards the held ID instruction anyway, so stalling for it is pointless.
  assign stall_o = hz && !flush_i;

  always_comb begin
    valid_d   = id_valid_i;
    rs_addr_d = id_rs_addr_i;
    rt_addr_d = id_rt_addr_i;
    rd_addr_d = id_rd_addr_i;
    rs_data_d = rs_byp;
    rt_data_d = rt_byp;
    imm_d     = id_imm_i;
    ctrl_d    = id_valid_i ? id_ctrl_i : '0;
    cnt_d     = cnt_q;

    if (flush_i || hz) begin
      valid_d   = 1'b0;
      rs_addr_d = '0;
      rt_addr_d = '0;
      rd_addr_d = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      ctrl_d    = '0;
      // Only load-use bubbles count; flushes are branch penalties, not hazards.
      if (!flush_i && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_valid_o   = valid_q;
  assign ex_rs_addr_o = rs_addr_q;
  assign ex_rt_addr_o = rt_addr_q;
  assign ex_rd_addr_o = rd_addr_q;
  assign ex_rs_data_o = rs_data_q;
  assign ex_rt_data_o = rt_data_q;
  assign ex_imm_o     = imm_q;
  assign ex_ctrl_o    = ctrl_q;
  assign bubble_cnt_o = cnt_q;

endmodule
